// File: rtl/elastic_reg_pipe_if.sv
// Handshake bundle for elastic_reg_pipe: upstream side, downstream side, hold/flush controls and occupancy.
// No logic inside; timing is set by the pipe that uses the slave modport.
// Backpressure is carried on in_ready (toward upstream) and out_ready (from downstream).
interface elastic_reg_pipe_if #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 3
);
    localparam int CW = $clog2(STAGES + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             hold;
    logic             flush;
    logic [CW-1:0]    count;

    // Driver / consumer side
    modport master (
        output in_valid, in_data, out_ready, hold, flush,
        input  in_ready, out_valid, out_data, count
    );

    // Pipe side
    modport slave (
        input  in_valid, in_data, out_ready, hold, flush,
        output in_ready, out_valid, out_data, count
    );
endinterface

// File: rtl/elastic_reg_pipe.sv
// Elastic register chain with per-stage valid bits, bubble collapse, whole-chain hold and one-cycle flush.
// Latency: STAGES cycles from input acceptance to out_valid when unstalled; one word per cycle throughput.
// Backpressure: in_ready is the combinational ready chain from out_ready, gated off during hold or flush.
module elastic_reg_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 3,
    localparam int CW    = $clog2(STAGES + 1)
) (
    input  logic           clk,
    input  logic           rst,
    elastic_reg_pipe_if.slave pipe
);

    logic [STAGES-1:0] v_q, v_d;
    logic [WIDTH-1:0]  d_q [STAGES];
    logic [CW-1:0]     count_q, count_d;

    logic              go;
    logic              in_ready_w;
    logic [STAGES-1:0] r;
    logic [STAGES-1:0] v_in;
    logic [WIDTH-1:0]  d_in [STAGES];
    logic [STAGES-1:0] load_en;

    assign go         = !pipe.hold && !pipe.flush;
    assign in_ready_w = r[0] && go;

    assign pipe.in_ready  = in_ready_w;
    assign pipe.out_valid = v_q[STAGES-1] && go;
    assign pipe.out_data  = d_q[STAGES-1];
    assign pipe.count     = count_q;

    // Ready chain: stage i can take a word unless it and every stage after it are full and the output stalls.
    // Written as an AND-reduction per stage so no bit of r depends on another bit of r.
    always_comb begin
        logic all_full;
        r = '0;
        for (int i = 0; i < STAGES; i++) begin
            all_full = 1'b1;
            for (int j = i; j < STAGES; j++) begin
                all_full = all_full && v_q[j];
            end
            r[i] = pipe.out_ready || !all_full;
        end
    end

    // What each stage would capture: the upstream handshake for stage 0, the previous stage otherwise.
    always_comb begin
        v_in    = '0;
        d_in[0] = pipe.in_data;
        v_in[0] = pipe.in_valid && in_ready_w;
        for (int i = 1; i < STAGES; i++) begin
            v_in[i] = v_q[i-1];
            d_in[i] = d_q[i-1];
        end
    end

    // Next valid vector, data load enables (only real words are written) and next occupancy.
    always_comb begin
        v_d     = v_q;
        load_en = '0;
        count_d = '0;
        if (pipe.flush) begin
            v_d = '0;
        end else if (go) begin
            for (int i = 0; i < STAGES; i++) begin
                if (r[i]) begin
                    v_d[i]     = v_in[i];
                    load_en[i] = v_in[i];
                end
            end
        end
        for (int i = 0; i < STAGES; i++) begin
            count_d = count_d + CW'(v_d[i]);
        end
    end

    // Valid bits and occupancy counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q     <= '0;
            count_q <= '0;
        end else begin
            v_q     <= v_d;
            count_q <= count_d;
        end
    end

    // Data registers; they hold their value across bubbles, flush and hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                d_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (load_en[i]) begin
                    d_q[i] <= d_in[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_elastic_reg_pipe.sv
// Directed bench for elastic_reg_pipe at WIDTH=8, STAGES=3.
// Inputs change on the falling edge; outputs are sampled 1 time unit later, away from the rising edge.
// Expected values are hand-derived constants per scenario.
module tb_elastic_reg_pipe;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    elastic_reg_pipe_if #(.WIDTH(8), .STAGES(3)) bus ();

    elastic_reg_pipe #(.WIDTH(8), .STAGES(3)) dut (
        .clk  (clk),
        .rst  (rst),
        .pipe (bus)
    );

    task automatic drive(input logic iv, input logic [7:0] id, input logic ordy,
                         input logic h, input logic f);
        bus.in_valid  = iv;
        bus.in_data   = id;
        bus.out_ready = ordy;
        bus.hold      = h;
        bus.flush     = f;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk); #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
        total++; if (bus.out_data !== 8'h00) begin bad++; $display("FAIL reset_out_data got=%h want=00", bus.out_data); end
        total++; if (bus.count !== 2'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", bus.count); end
        #1 rst = 1'b0;
    endtask

    task automatic test_throughput();
        logic [7:0] words [4];
        int         cnt   [8];
        logic       exp_v;
        words = '{8'h11, 8'h22, 8'h33, 8'h44};
        cnt   = '{0, 1, 2, 3, 3, 2, 1, 0};
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            drive(c < 4, (c < 4) ? words[c] : 8'h00, 1'b1, 1'b0, 1'b0);
            #1;
            exp_v = (c >= 3) && (c <= 6);
            total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL thru_in_ready c=%0d got=%b want=1", c, bus.in_ready); end
            total++; if (bus.out_valid !== exp_v) begin bad++; $display("FAIL thru_out_valid c=%0d got=%b want=%b", c, bus.out_valid, exp_v); end
            if (exp_v) begin
                total++; if (bus.out_data !== words[c-3]) begin bad++; $display("FAIL thru_out_data c=%0d got=%h want=%h", c, bus.out_data, words[c-3]); end
            end
            total++; if (int'(bus.count) != cnt[c]) begin bad++; $display("FAIL thru_count c=%0d got=%0d want=%0d", c, bus.count, cnt[c]); end
        end
    endtask

    task automatic test_stall();
        logic [7:0] exp_d;
        int         exp_c;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(1'b1, 8'hA1 + 8'(k), 1'b0, 1'b0, 1'b0);
            #1;
            total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL stall_fill_ready k=%0d got=%b want=1", k, bus.in_ready); end
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            drive(1'b1, 8'hA4, 1'b0, 1'b0, 1'b0);
            #1;
            total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL stall_full_ready k=%0d got=%b want=0", k, bus.in_ready); end
            total++; if (bus.count !== 2'd3) begin bad++; $display("FAIL stall_full_count k=%0d got=%0d want=3", k, bus.count); end
            total++; if (bus.out_data !== 8'hA1) begin bad++; $display("FAIL stall_full_data k=%0d got=%h want=a1", k, bus.out_data); end
            total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL stall_full_valid k=%0d got=%b want=1", k, bus.out_valid); end
        end
        @(negedge clk);
        drive(1'b1, 8'hA4, 1'b1, 1'b0, 1'b0);
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL stall_passthru_ready got=%b want=1", bus.in_ready); end
        total++; if (bus.out_data !== 8'hA1) begin bad++; $display("FAIL stall_drain_a1 got=%h want=a1", bus.out_data); end
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            #1;
            exp_d = 8'hA1 + 8'(k);
            exp_c = (k == 1) ? 3 : ((k == 2) ? 2 : 1);
            total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL stall_drain_valid k=%0d got=%b want=1", k, bus.out_valid); end
            total++; if (bus.out_data !== exp_d) begin bad++; $display("FAIL stall_drain_data k=%0d got=%h want=%h", k, bus.out_data, exp_d); end
            total++; if (int'(bus.count) != exp_c) begin bad++; $display("FAIL stall_drain_count k=%0d got=%0d want=%0d", k, bus.count, exp_c); end
        end
        @(negedge clk); #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL stall_empty_valid got=%b want=0", bus.out_valid); end
        total++; if (bus.count !== 2'd0) begin bad++; $display("FAIL stall_empty_count got=%0d want=0", bus.count); end
    endtask

    task automatic test_bubble_collapse();
        @(negedge clk); drive(1'b1, 8'h05, 1'b0, 1'b0, 1'b0);
        @(negedge clk); drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk); drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk); drive(1'b1, 8'h06, 1'b0, 1'b0, 1'b0);
        @(negedge clk); drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk); drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        #1;
        total++; if (bus.count !== 2'd2) begin bad++; $display("FAIL bubble_count got=%0d want=2", bus.count); end
        total++; if (dut.v_q !== 3'b110) begin bad++; $display("FAIL bubble_valid_vec got=%b want=110", dut.v_q); end
        total++; if (bus.out_data !== 8'h05) begin bad++; $display("FAIL bubble_head got=%h want=05", bus.out_data); end
        @(negedge clk); drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        #1;
        total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h05) begin bad++; $display("FAIL bubble_out1 got=%b/%h want=1/05", bus.out_valid, bus.out_data); end
        @(negedge clk); #1;
        total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h06) begin bad++; $display("FAIL bubble_out2 got=%b/%h want=1/06", bus.out_valid, bus.out_data); end
        @(negedge clk); #1;
        total++; if (bus.out_valid !== 1'b0 || bus.count !== 2'd0) begin bad++; $display("FAIL bubble_empty got=%b/%0d want=0/0", bus.out_valid, bus.count); end
    endtask

    task automatic test_hold();
        @(negedge clk); drive(1'b1, 8'h10, 1'b0, 1'b0, 1'b0);
        @(negedge clk); drive(1'b1, 8'h20, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            drive(1'b1, 8'h99, 1'b1, 1'b1, 1'b0);
            #1;
            total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL hold_in_ready k=%0d got=%b want=0", k, bus.in_ready); end
            total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL hold_out_valid k=%0d got=%b want=0", k, bus.out_valid); end
            total++; if (bus.count !== 2'd2) begin bad++; $display("FAIL hold_count k=%0d got=%0d want=2", k, bus.count); end
        end
        @(negedge clk); drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        #1;
        total++; if (bus.out_valid !== 1'b0 || bus.count !== 2'd2) begin bad++; $display("FAIL hold_release got=%b/%0d want=0/2", bus.out_valid, bus.count); end
        @(negedge clk); #1;
        total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h10) begin bad++; $display("FAIL hold_out1 got=%b/%h want=1/10", bus.out_valid, bus.out_data); end
        @(negedge clk); #1;
        total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h20) begin bad++; $display("FAIL hold_out2 got=%b/%h want=1/20", bus.out_valid, bus.out_data); end
        @(negedge clk); #1;
        total++; if (bus.out_valid !== 1'b0 || bus.count !== 2'd0) begin bad++; $display("FAIL hold_empty got=%b/%0d want=0/0", bus.out_valid, bus.count); end
    endtask

    task automatic test_flush();
        logic exp_v;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(1'b1, 8'h31 + 8'(k), 1'b0, 1'b0, 1'b0);
        end
        @(negedge clk); drive(1'b1, 8'hEE, 1'b0, 1'b1, 1'b1);
        #1;
        total++; if (bus.count !== 2'd3) begin bad++; $display("FAIL flush_pre_count got=%0d want=3", bus.count); end
        total++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_gating got=%b/%b want=0/0", bus.in_ready, bus.out_valid); end
        @(negedge clk); drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        #1;
        total++; if (bus.count !== 2'd0) begin bad++; $display("FAIL flush_count got=%0d want=0", bus.count); end
        total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL flush_empty got=%b/%b want=0/1", bus.out_valid, bus.in_ready); end
        @(negedge clk); drive(1'b1, 8'h40, 1'b1, 1'b0, 1'b0);
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL flush_accept got=%b want=1", bus.in_ready); end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            #1;
            exp_v = (k == 3);
            total++; if (bus.out_valid !== exp_v) begin bad++; $display("FAIL flush_next_valid k=%0d got=%b want=%b", k, bus.out_valid, exp_v); end
            if (exp_v) begin
                total++; if (bus.out_data !== 8'h40) begin bad++; $display("FAIL flush_next_data got=%h want=40", bus.out_data); end
            end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk); drive(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
        @(negedge clk); drive(1'b1, 8'h66, 1'b0, 1'b0, 1'b0);
        @(negedge clk); drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk); #1;
        total++; if (bus.count !== 2'd2 || bus.out_valid !== 1'b1 || bus.out_data !== 8'h55) begin bad++; $display("FAIL arst_pre got=%0d/%b/%h want=2/1/55", bus.count, bus.out_valid, bus.out_data); end
        drive(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL arst_out_valid got=%b want=0", bus.out_valid); end
        total++; if (bus.out_data !== 8'h00) begin bad++; $display("FAIL arst_out_data got=%h want=00", bus.out_data); end
        total++; if (bus.count !== 2'd0) begin bad++; $display("FAIL arst_count got=%0d want=0", bus.count); end
        @(negedge clk);
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        #2 rst = 1'b0;
        @(negedge clk); #1;
        total++; if (bus.count !== 2'd0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL arst_after got=%0d/%b/%b want=0/1/0", bus.count, bus.in_ready, bus.out_valid); end
    endtask

    initial begin
        test_reset();
        test_throughput();
        test_stall();
        test_bubble_collapse();
        test_hold();
        test_flush();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/elastic_reg_pipe.md
# elastic_reg_pipe

Parametrised, edge-triggered pipeline register chain with per-stage valid bits and a valid/ready handshake on both ends. It replaces hand-instantiated latch/register banks between approximate-adder and multiplier stages of the CNN datapath. Internal bubbles collapse, a hold input freezes the whole chain (the multi-stage successor of a write-enable latch), and a flush input empties it in one cycle.

## Interface
- WIDTH, 16, data bits per stage (≥1)
- STAGES, 3, number of register stages (≥1)
- CW, $clog2(STAGES+1), width of occupancy count (derived, not overridden)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream word present
- in_ready  out  1  pipe accepts word this cycle
- in_data  in  WIDTH  upstream word
- out_valid  out  1  word available at output
- out_ready  in  1  downstream accepts word
- out_data  out  WIDTH  output word (stage STAGES-1)
- hold  in  1  freeze all stages, no transfers
- flush  in  1  discard all contents at next edge
- count  out  CW  number of occupied stages (registered)

## Operation
- Stage i holds v[i], d[i]; stage 0 is input side, stage STAGES-1 drives out_data.
- Chain ready (combinational): r[STAGES] = out_ready; r[i] = !v[i] | r[i+1].
- Gating: go = !hold & !flush.
- in_ready = r[0] & go; out_valid = v[STAGES-1] & go; out_data = d[STAGES-1] always (unqualified).
- Input transfer: in_valid & in_ready. Output transfer: out_valid & out_ready.
- At edge, when go: stage i (i>0) loads v[i-1], d[i-1] if r[i]; stage 0 loads in_valid & in_ready, in_data if r[0]; a stage whose r[i]=0 keeps its contents. Data register loads only when its incoming valid is 1 (no data toggling on bubbles).
- Bubble collapse: a valid word advances whenever the next stage is empty or moving, regardless of output stall.
- hold=1 (flush=0): all v, d, count unchanged; in_ready=0, out_valid=0.
- flush=1: all v cleared at next edge; d unchanged; count→0; in_ready=0, out_valid=0. flush has priority over hold.
- count = number of v[i]=1 after the edge; updated every cycle.
- No state machine beyond the valid vector; all stages identical.

## Timing
- Reset (async, immediate): all v=0, all d=0, count=0; hence in_ready=1 (if hold=flush=0), out_valid=0, out_data=0.
- Release of rst is not synchronised internally; the driver deasserts it away from clk edges.
- Latency: word accepted at edge N is at output (out_valid=1) after edge N+STAGES-1, i.e. STAGES cycles of occupancy, when never stalled.
- Throughput: one word per cycle with out_ready=1 continuously; in_ready stays 1 when full and out_ready=1 (pass-through, no bubble).
- Full (all v=1) and out_ready=0: in_ready=0, nothing moves.
- Empty: out_valid=0, in_ready=go.
- Simultaneous in/out transfer when full: count unchanged.
- flush with in_valid=1: input word not accepted, dropped by upstream handshake rules (upstream keeps it since in_ready=0).
- rst mid-transfer: contents lost, outputs at reset values immediately, no spurious out_valid.
- STAGES=1: degenerates to a single register with ready = !v | out_ready.

## Test plan
- WIDTH=8, STAGES=3: reset, then in_valid=1 with 0x11,0x22,0x33,0x44 on consecutive cycles, out_ready=1 -> out_valid first high 3 cycles after 0x11 accepted, outputs 0x11..0x44 on consecutive cycles, count peaks at 3, in_ready never drops.
- Stall: out_ready=0, push 0xA1,0xA2,0xA3,0xA4 -> first three accepted, in_ready=0 with count=3, out_data=0xA1; raise out_ready -> 0xA1,0xA2,0xA3,0xA4 exit in order, no loss or duplicate.
- Bubble collapse: push 0x05, idle 2 cycles, push 0x06 with out_ready=0 -> count=2 and v[2],v[1] set after 4 cycles (words packed at output end).
- Hold: pipe with 0x10,0x20 inside, hold=1 for 5 cycles with in_valid=1, out_ready=1 -> in_ready=0, out_valid=0, count constant 2; after release 0x10,0x20 emerge unchanged.
- Flush: pipe full (0x31,0x32,0x33), assert flush and hold together for 1 cycle -> count=0, out_valid=0 next cycle; next accepted word 0x40 exits after 3 cycles with no stale data.
- Async reset mid-stream: assert rst between edges while count=2 -> out_valid=0, out_data=0, count=0 before next edge.
